load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 151 +++++++++++++++
 tb/tb_load_store_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit between a CPU pipeline and a combinational-read word RAM.
// Sub-word stores use a read-modify-write; misaligned or illegal accesses end in a one-cycle error pulse.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_we,
  input  logic [2:0]            i_funct3,
  input  logic [31:0]           i_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata,
  output logic                  o_done,
  output logic                  o_misalign,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  input  logic [31:0]           i_mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, LOAD, RMW_RD, WRITE, DONE, ERR
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t                state_q, state_d;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [1:0]            off_q;
  logic [31:0]           wdata_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [31:0]           mem_wdata_q;
  logic [31:0]           rdata_q;

  logic                  accept;
  logic                  illegal;
  logic [31:0]           load_val;
  logic [31:0]           merged;

  assign accept = (state_q == IDLE) && i_valid;

  // Unsupported codes, stores of BU/HU, and widths not naturally aligned.
  always_comb begin
    unique case (i_funct3)
      F3_B:    illegal = 1'b0;
      F3_H:    illegal = i_addr[0];
      F3_W:    illegal = |i_addr[1:0];
      F3_BU:   illegal = i_we;
      F3_HU:   illegal = i_we | i_addr[0];
      default: illegal = 1'b1;
    endcase
  end

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: the default assignment first keeps this combinational block from inferring a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          if (illegal)              state_d = ERR;
          else if (!i_we)           state_d = LOAD;
          else if (i_funct3 == F3_W) state_d = WRITE;
          else                      state_d = RMW_RD;
        end
      end
      LOAD:    state_d = DONE;
      RMW_RD:  state_d = WRITE;
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the state.
  always_comb begin
    o_ready    = (state_q == IDLE);
    o_mem_we   = (state_q == WRITE) && we_q;
    o_done     = (state_q == DONE) || (state_q == ERR);
    o_misalign = (state_q == ERR);
  end

  // Extract and extend the addressed lane of the RAM word (little-endian).
  always_comb begin
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    lane_b = i_mem_rdata[{off_q, 3'b000} +: 8];
    lane_h = off_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    unique case (funct3_q)
      F3_B:    load_val = {{24{lane_b[7]}}, lane_b};
      F3_H:    load_val = {{16{lane_h[15]}}, lane_h};
      F3_BU:   load_val = {24'h0, lane_b};
      F3_HU:   load_val = {16'h0, lane_h};
      default: load_val = i_mem_rdata;
    endcase
  end

  // Replace only the target lane of the word read back for a sub-word store.
  always_comb begin
    merged = i_mem_rdata;
    if (funct3_q == F3_B) merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    else                  merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  // Datapath registers.
  // NOTE: every datapath register is reset because the cleared values are architecturally
  // visible on the outputs straight after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      we_q        <= 1'b0;
      funct3_q    <= F3_B;
      off_q       <= 2'b00;
      wdata_q     <= 32'h0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
    end else begin
      if (accept) begin
        we_q       <= i_we;
        funct3_q   <= i_funct3;
        off_q      <= i_addr[1:0];
        wdata_q    <= i_wdata;
        mem_addr_q <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
        if (i_we && !illegal && i_funct3 == F3_W) mem_wdata_q <= i_wdata;
      end
      if (state_q == LOAD)   rdata_q     <= load_val;
      if (state_q == RMW_RD) mem_wdata_q <= merged;
    end
  end

  assign o_rdata     = rdata_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected completions and RAM writes are queued
// at issue time and compared by independent monitors when the DUT presents them.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        ready;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        mis;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (valid),
    .o_ready     (ready),
    .i_we        (we),
    .i_funct3    (funct3),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .o_rdata     (rdata),
    .o_done      (done),
    .o_misalign  (mis),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata)
  );

  typedef struct {
    int          done_cyc;
    bit          mis;
    logic [31:0] rd;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  exp_t        exp_q[$];
  wr_t         wr_q[$];
  logic [31:0] ram[64];
  logic [7:0]  ref_mem[256];
  logic [31:0] last_rd;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  exp_t        mon_e;
  wr_t         mon_w;

  // RAM: combinational read, posedge write.
  assign mem_rdata = ram[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Completion and write monitors.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_cycle", 32'(cyc), 32'(mon_e.done_cyc));
        check("misalign", {31'h0, mis}, {31'h0, mon_e.mis});
        check("rdata", rdata, mon_e.rd);
      end
    end
    if (mem_we === 1'b1) begin
      if (wr_q.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_write actual=%h@%h required=none", mem_wdata, mem_addr);
      end else begin
        mon_w = wr_q.pop_front();
        check("write_addr", mem_addr, mon_w.addr);
        check("write_data", mem_wdata, mon_w.data);
      end
    end
  end

  function automatic bit model_mis(input bit w, input logic [2:0] f, input logic [7:0] a);
    case (f)
      3'b000:  return 1'b0;
      3'b001:  return a[0];
      3'b010:  return a[1:0] != 2'b00;
      3'b100:  return w;
      3'b101:  return w | a[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] ref_word(input logic [7:0] a);
    int b;
    b = int'({a[7:2], 2'b00});
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [7:0] a);
    logic [7:0] b0, b1;
    b0 = ref_mem[int'(a)];
    b1 = ref_mem[int'(a) + 1];
    case (f)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b100:  return {24'h0, b0};
      3'b101:  return {16'h0, b1, b0};
      default: return ref_word(a);
    endcase
  endfunction

  task automatic ref_store(input logic [2:0] f, input logic [7:0] a, input logic [31:0] d);
    int n;
    n = (f == 3'b000) ? 1 : (f == 3'b001) ? 2 : 4;
    for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = d[8*i +: 8];
  endtask

  // Drive a request, hold it until accepted, and queue what the DUT must produce.
  // Latency counts the acceptance edge itself.
  task automatic do_req(input bit w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input bit exp_mis, input logic [31:0] exp_rd,
                        input logic [31:0] exp_wa, input logic [31:0] exp_wd,
                        input int lat, input bit track);
    bit   rdy;
    int   n;
    exp_t e;
    wr_t  wr;
    @(negedge clk);
    valid = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
    rdy = ready;
    n = 0;
    while (!rdy && n < 100) begin
      @(negedge clk);
      rdy = ready;
      n++;
    end
    if (!rdy) begin
      total++; bad++;
      $display("FAIL accept_timeout actual=not_ready required=ready");
      valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (track) begin
      e.done_cyc = cyc + lat - 1;
      e.mis = exp_mis;
      e.rd = exp_rd;
      exp_q.push_back(e);
      if (w && !exp_mis) begin
        wr.addr = exp_wa;
        wr.data = exp_wd;
        wr_q.push_back(wr);
      end
    end
  endtask

  // Request whose expectations come from the byte-addressed reference model.
  task automatic model_req(input bit w, input logic [2:0] f, input logic [7:0] a,
                           input logic [31:0] d);
    bit          m;
    logic [31:0] wa, wd;
    int          lat;
    m = model_mis(w, f, a);
    wa = 32'h0; wd = 32'h0;
    if (m) begin
      lat = 1;
    end else if (!w) begin
      last_rd = ref_load(f, a);
      lat = 2;
    end else begin
      ref_store(f, a, d);
      wa = {24'h0, a[7:2], 2'b00};
      wd = ref_word(a);
      lat = (f == 3'b010) ? 2 : 3;
    end
    do_req(w, f, {24'h0, a}, d, m, last_rd, wa, wd, lat, 1'b1);
  endtask

  task automatic drain();
    int n;
    @(negedge clk);
    valid = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || wr_q.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || wr_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout actual=%0d/%0d pending required=0", exp_q.size(), wr_q.size());
      exp_q.delete();
      wr_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'h0, ready}, 32'h1);
    check({tag, "_done"}, {31'h0, done}, 32'h0);
    check({tag, "_misalign"}, {31'h0, mis}, 32'h0);
    check({tag, "_mem_we"}, {31'h0, mem_we}, 32'h0);
    check({tag, "_rdata"}, rdata, 32'h0);
    check({tag, "_mem_addr"}, mem_addr, 32'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] f3_tab[10];
    rst = 1'b1; valid = 1'b0; we = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    last_rd = 32'h0;
    for (int i = 0; i < 64; i++) ram[i] = 32'hA500_0000 ^ (i * 32'h0103_0507);
    ram[4] = 32'h8000_00F0;
    ram[8] = 32'h1122_3344;
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 4; j++) ref_mem[4*i + j] = ram[i][8*j +: 8];

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Signed and unsigned byte loads of the top byte of word 0x10.
    do_req(1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 32'hFFFF_FF80, 32'h0, 32'h0, 2, 1'b1);
    drain();
    do_req(1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 32'h0000_0080, 32'h0, 32'h0, 2, 1'b1);
    drain();
    last_rd = 32'h0000_0080;

    // Upper-halfword store via read-modify-write.
    do_req(1'b1, 3'b001, 32'h22, 32'hAAAA_BEEF, 1'b0, 32'h0000_0080,
           32'h20, 32'hBEEF_3344, 3, 1'b1);
    ref_store(3'b001, 8'h22, 32'hAAAA_BEEF);
    drain();
    check("ram_0x20", ram[8], 32'hBEEF_3344);

    // Misaligned word store: error pulse only.
    do_req(1'b1, 3'b010, 32'h41, 32'hDEAD_BEEF, 1'b1, 32'h0000_0080, 32'h0, 32'h0, 1, 1'b1);
    drain();

    // Reset during the RMW_RD cycle of a byte store aborts it.
    do_req(1'b1, 3'b000, 32'h31, 32'h0000_0055, 1'b0, 32'h0, 32'h0, 32'h0, 3, 1'b0);
    rst = 1'b1;
    valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("abort");
    rst = 1'b0;
    last_rd = 32'h0;
    drain();
    check("abort_ram_0x30", ram[12], ref_word(8'h30));

    // Back-to-back: second request held on i_valid until the unit is idle again.
    model_req(1'b0, 3'b010, 8'h00, 32'h0);
    model_req(1'b1, 3'b010, 8'h04, 32'h1234_5678);
    drain();
    check("b2b_ram_0x04", ram[1], 32'h1234_5678);

    // Mixed widths, offsets and sign bits against the reference model.
    f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b000, 3'b001, 3'b010, 3'b100, 3'b011};
    for (int i = 0; i < 120; i++) begin
      model_req(1'($urandom_range(0, 1)), f3_tab[$urandom_range(0, 9)],
                8'($urandom_range(0, 255)), $urandom);
      if (i % 4 == 3) drain();
    end
    drain();

    for (int i = 0; i < 64; i++) check("final_ram", ram[i], ref_word(8'(4 * i)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
